pll_reset_ctrl: RTL and testbench
=================================

Name: pll_reset_ctrl

Overview:
- Reset sequencer directly downstream of the iCE40 SB_PLL40_CORE wrapper on the BlackIce Murax build.
- Runs on the PLL global output clock and consumes the PLL LOCK flag.
- Holds the Murax system reset asserted until lock has been stable for a programmable time.
- Re-asserts reset on lock loss or on a software reset request, and counts lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on io_pllLock (minimum 2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before reset release (minimum 1).
- RESET_HOLD_CYCLES, 64, reset pulse length in cycles for a software reset (minimum 1).
- CNT_WIDTH, 16, width of the internal cycle counter; must hold max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES) - 1.

Ports:
- io_mainClk  input  1  PLL output clock (PLLOUTGLOBAL).
- io_asyncReset  input  1  asynchronous, active-high reset; clears all state.
- io_pllLock  input  1  PLL LOCK flag, asynchronous to io_mainClk.
- io_softReset  input  1  synchronous request for a system reset pulse, single-cycle or level.
- io_systemReset  output  1  registered, active-high reset to the Murax core.
- io_locked  output  1  synchronized lock flag (last synchronizer stage).
- io_lockLossCount  output  8  saturating count of lock losses seen in RUN or HOLD.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high (io_asyncReset). All flops clear on it.
- Reset values:
  - state = WAIT_LOCK, counter = 0, synchronizer flops = 0.
  - io_systemReset = 1, io_locked = 0, io_lockLossCount = 0.
- Synchronizer: io_pllLock passes through SYNC_STAGES flops to form lock_s. io_locked = lock_s.
- io_systemReset is a register, equal to 1 whenever the state is not RUN. It is therefore 0 from the first cycle in RUN, with no combinational path from any input.
- WAIT_LOCK: counter held at 0. When lock_s = 1, go to STABILIZE with counter = 0.
- STABILIZE:
  - lock_s = 0: return to WAIT_LOCK and clear the counter. The loss counter is not incremented.
  - Else if counter == LOCK_STABLE_CYCLES - 1: go to RUN.
  - Else: counter + 1.
- RUN:
  - lock_s = 0: go to WAIT_LOCK and increment io_lockLossCount.
  - Else if io_softReset = 1: go to HOLD with counter = 0.
  - Lock loss has priority over soft reset when both occur in the same cycle.
- HOLD:
  - lock_s = 0: go to WAIT_LOCK and increment io_lockLossCount.
  - Else if io_softReset = 1: restart the counter at 0.
  - Else if counter == RESET_HOLD_CYCLES - 1: go to RUN.
  - Else: counter + 1.
- io_softReset is ignored in WAIT_LOCK and STABILIZE; reset is already asserted there.
- io_lockLossCount saturates at 255 and never wraps.
- Release latency: counting the first edge that samples io_pllLock = 1 as edge 1, io_systemReset falls after edge SYNC_STAGES + LOCK_STABLE_CYCLES + 1, provided lock stays high.
- Lock-loss latency: io_systemReset rises after edge SYNC_STAGES + 1, counting the first edge that samples io_pllLock = 0 as edge 1.
- Soft-reset timing: io_systemReset rises on the edge that samples io_softReset = 1 in RUN and stays high for exactly RESET_HOLD_CYCLES cycles.
- io_asyncReset mid-operation: outputs return to reset values immediately, without waiting for a clock edge. After release, the full stabilization sequence runs again.
- Lock glitches shorter than SYNC_STAGES cycles may be filtered or seen. Any glitch that reaches lock_s during STABILIZE restarts the stabilization count.

Test Plan:
1. Release timing: SYNC_STAGES = 2, LOCK_STABLE_CYCLES = 4; hold io_asyncReset, release it, then raise io_pllLock -> io_systemReset = 1 through edge 6, 0 after edge 7; io_locked = 1 after edge 2.
2. Stabilization restart: lock high for 2 cycles, low for 1 cycle, then high -> no release until 4 uninterrupted lock_s cycles have elapsed; io_lockLossCount = 0.
3. Lock loss in RUN: drop io_pllLock -> io_systemReset = 1 after 3 edges; io_lockLossCount = 1. Re-lock -> release again after 7 edges.
4. Soft reset: RESET_HOLD_CYCLES = 3, one-cycle io_softReset in RUN -> io_systemReset high for exactly 3 cycles, then 0. A second io_softReset on the 2nd hold cycle extends the pulse to 2 + 3 cycles.
5. Simultaneous events: lock_s falls in the same cycle io_softReset = 1 in RUN -> state goes to WAIT_LOCK, count increments, no release until re-lock plus 4 cycles.
6. Saturation and async reset: 300 lock-loss events -> io_lockLossCount = 255. Assert io_asyncReset mid-STABILIZE with no clock edge -> io_systemReset = 1 and count = 0 immediately.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// Reset sequencer behind the iCE40 PLL: holds the Murax system reset until the PLL
// lock flag has been stable long enough, re-asserts it on lock loss or soft reset.
module pll_reset_ctrl #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 64,
  parameter int CNT_WIDTH          = 16
) (
  input  logic       io_mainClk,
  input  logic       io_asyncReset,
  input  logic       io_pllLock,
  input  logic       io_softReset,
  output logic       io_systemReset,
  output logic       io_locked,
  output logic [7:0] io_lockLossCount
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_sys_rst;
  logic [7:0]             r_loss_cnt;

  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic                   w_loss_evt;
  logic                   w_lock_s;

  // io_pllLock is asynchronous to io_mainClk; only the last stage is used.
  // NOTE: sequential state is written with non-blocking assignments so every flop
  // samples pre-edge values, which is what makes the shift chain a real chain.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io_pllLock};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss_evt  = 1'b0;
    unique case (r_state)
      WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (w_lock_s) w_state_nxt = STABILIZE;
      end
      STABILIZE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        // Lock loss wins over a simultaneous soft reset request.
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_loss_evt  = 1'b1;
        end else if (io_softReset) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_loss_evt  = 1'b1;
        end else if (io_softReset) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Registered from the next state so reset drops on the very edge that enters RUN.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_sys_rst <= 1'b1;
    end else begin
      r_sys_rst <= (w_state_nxt != RUN);
    end
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign io_systemReset   = r_sys_rst;
  assign io_locked        = w_lock_s;
  assign io_lockLossCount = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with SYNC_STAGES=2, LOCK_STABLE_CYCLES=4,
// RESET_HOLD_CYCLES=3; expected values are hand-derived edge counts.
module tb_pll_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       soft_rst;
  logic       sys_rst;
  logic       locked;
  logic [7:0] loss_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  pll_reset_ctrl #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(4),
    .RESET_HOLD_CYCLES (3),
    .CNT_WIDTH         (16)
  ) dut (
    .io_mainClk      (clk),
    .io_asyncReset   (rst),
    .io_pllLock      (pll_lock),
    .io_softReset    (soft_rst),
    .io_systemReset  (sys_rst),
    .io_locked       (locked),
    .io_lockLossCount(loss_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    pll_lock = 1'b0;
    soft_rst = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (sys_rst !== 1'b1 || locked !== 1'b0 || loss_cnt !== 8'd0) begin
      $display("FAIL reset_values: sys_rst=%b locked=%b loss=%0d, want 1 0 0", sys_rst, locked, loss_cnt);
      tests_failed++;
    end
  endtask

  // Raise lock and check release after edge 7 and io_locked after edge 2.
  task automatic test_release_timing();
    pll_lock = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      tests_run++;
      if (sys_rst !== (k < 7)) begin
        $display("FAIL release_edge%0d: sys_rst=%b want %b", k, sys_rst, (k < 7));
        tests_failed++;
      end
      tests_run++;
      if (locked !== (k >= 2)) begin
        $display("FAIL locked_edge%0d: locked=%b want %b", k, locked, (k >= 2));
        tests_failed++;
      end
    end
  endtask

  // Lock 1,1,0 then 1: the glitch reaches lock_s in STABILIZE, release moves to edge 10.
  task automatic test_stabilize_restart();
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      pll_lock = (k != 3);
      tick();
      tests_run++;
      if (sys_rst !== (k < 10)) begin
        $display("FAIL restart_edge%0d: sys_rst=%b want %b", k, sys_rst, (k < 10));
        tests_failed++;
      end
    end
    tests_run++;
    if (loss_cnt !== 8'd0) begin
      $display("FAIL restart_loss: loss=%0d want 0", loss_cnt);
      tests_failed++;
    end
  endtask

  // Drop lock from RUN, expecting reset after edge 3; re-lock releases after edge 7.
  task automatic drop_and_relock(input logic [7:0] exp_cnt, input string tag);
    pll_lock = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests_run++;
      if (sys_rst !== (k == 3)) begin
        $display("FAIL %s_loss_edge%0d: sys_rst=%b want %b", tag, k, sys_rst, (k == 3));
        tests_failed++;
      end
    end
    tests_run++;
    if (loss_cnt !== exp_cnt) begin
      $display("FAIL %s_loss_cnt: loss=%0d want %0d", tag, loss_cnt, exp_cnt);
      tests_failed++;
    end
    pll_lock = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k >= 6) begin
        tests_run++;
        if (sys_rst !== (k < 7)) begin
          $display("FAIL %s_relock_edge%0d: sys_rst=%b want %b", tag, k, sys_rst, (k < 7));
          tests_failed++;
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    drop_and_relock(8'd1, "run");
  endtask

  // Pulse soft reset, optionally re-requesting it on the 2nd hold cycle.
  task automatic soft_pulse(input bit extend, input int high_edges, input string tag);
    soft_rst = 1'b1;
    for (int k = 0; k <= high_edges; k++) begin
      tick();
      soft_rst = (extend && k == 1);
      tests_run++;
      if (sys_rst !== (k < high_edges)) begin
        $display("FAIL %s_edge%0d: sys_rst=%b want %b", tag, k, sys_rst, (k < high_edges));
        tests_failed++;
      end
    end
  endtask

  task automatic test_soft_reset();
    soft_pulse(1'b0, 3, "soft_single");
    tick();
    soft_pulse(1'b1, 5, "soft_extend");
    tick();
  endtask

  // Soft reset arrives on the same edge that sees lock_s fall: lock loss wins.
  task automatic test_back_to_back();
    pll_lock = 1'b0;
    tick();
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    tests_run++;
    if (sys_rst !== 1'b1 || loss_cnt !== 8'd2) begin
      $display("FAIL simul_edge: sys_rst=%b loss=%0d want 1 2", sys_rst, loss_cnt);
      tests_failed++;
    end
    tick();
    tick();
    tests_run++;
    if (loss_cnt !== 8'd2) begin
      $display("FAIL simul_no_hold: loss=%0d want 2", loss_cnt);
      tests_failed++;
    end
    pll_lock = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      tests_run++;
      if (sys_rst !== (k < 7)) begin
        $display("FAIL simul_relock_edge%0d: sys_rst=%b want %b", k, sys_rst, (k < 7));
        tests_failed++;
      end
    end
  endtask

  task automatic test_saturation_async();
    // Count is 2 here; after 253 more losses it reaches 255 and must stay there.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      repeat (3) tick();
      pll_lock = 1'b1;
      repeat (7) tick();
      if (i == 252 || i == 253) begin
        tests_run++;
        if (loss_cnt !== 8'd255) begin
          $display("FAIL sat_iter%0d: loss=%0d want 255", i, loss_cnt);
          tests_failed++;
        end
      end
    end
    tests_run++;
    if (loss_cnt !== 8'd255 || sys_rst !== 1'b0) begin
      $display("FAIL sat_final: loss=%0d sys_rst=%b want 255 0", loss_cnt, sys_rst);
      tests_failed++;
    end
    // Enter STABILIZE, then assert the async reset between clock edges.
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (sys_rst !== 1'b1 || loss_cnt !== 8'd0 || locked !== 1'b0) begin
      $display("FAIL async_mid: sys_rst=%b loss=%0d locked=%b want 1 0 0", sys_rst, loss_cnt, locked);
      tests_failed++;
    end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      tests_run++;
      if (sys_rst !== (k < 7)) begin
        $display("FAIL async_rerun_edge%0d: sys_rst=%b want %b", k, sys_rst, (k < 7));
        tests_failed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_release_timing();
    test_stabilize_restart();
    test_lock_loss();
    test_soft_reset();
    test_back_to_back();
    test_saturation_async();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
